// File: rtl/alu_issue_ctrl_if.sv
// Instruction, ALU and writeback signal bundle for alu_issue_ctrl.
// The controller uses the slave modport; the instruction source / ALU side uses master.
interface alu_issue_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [2:0]  in_rd;
    logic [2:0]  in_rs2;
    logic [2:0]  in_rs3;
    logic [31:0] in_imm;
    logic [2:0]  alu_op;
    logic [31:0] alu_r2;
    logic [31:0] alu_r3;
    logic [31:0] alu_r1;
    logic        res_valid;
    logic [2:0]  res_rd;
    logic [31:0] res_data;

    modport master (
        output in_valid, in_op, in_rd, in_rs2, in_rs3, in_imm, alu_r1,
        input  in_ready, alu_op, alu_r2, alu_r3, res_valid, res_rd, res_data
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs2, in_rs3, in_imm, alu_r1,
        output in_ready, alu_op, alu_r2, alu_r3, res_valid, res_rd, res_data
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for a combinational 32-bit ALU with an 8x32 register file.
// One instruction in flight: IDLE -> EXEC -> WB for ALU ops, IDLE -> WB for LOADI.
module alu_issue_ctrl (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_ctrl_if.slave   bus,
    input  logic [2:0]        dbg_addr,
    output logic [31:0]       dbg_data
);
    localparam logic [2:0] OpLoadi = 3'b111;

    typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

    state_e      state_q, state_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic [31:0] alu_r2_q, alu_r2_d;
    logic [31:0] alu_r3_q, alu_r3_d;
    logic [2:0]  rd_q, rd_d;
    logic [2:0]  res_rd_q, res_rd_d;
    logic [31:0] res_data_q, res_data_d;
    logic [31:0] rf_q [8];
    logic        rf_we;

    always_comb begin
        state_d    = state_q;
        alu_op_d   = alu_op_q;
        alu_r2_d   = alu_r2_q;
        alu_r3_d   = alu_r3_q;
        rd_d       = rd_q;
        res_rd_d   = res_rd_q;
        res_data_d = res_data_q;
        rf_we      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    if (bus.in_op == OpLoadi) begin
                        // LOADI bypasses the ALU and leaves its ports untouched
                        res_data_d = bus.in_imm;
                        res_rd_d   = bus.in_rd;
                        state_d    = StWb;
                    end else begin
                        alu_op_d = bus.in_op;
                        alu_r2_d = rf_q[bus.in_rs2];
                        alu_r3_d = rf_q[bus.in_rs3];
                        rd_d     = bus.in_rd;
                        state_d  = StExec;
                    end
                end
            end
            StExec: begin
                res_data_d = bus.alu_r1;
                res_rd_d   = rd_q;
                state_d    = StWb;
            end
            StWb: begin
                rf_we   = (res_rd_q != 3'd0);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            alu_op_q   <= 3'd0;
            alu_r2_q   <= 32'd0;
            alu_r3_q   <= 32'd0;
            rd_q       <= 3'd0;
            res_rd_q   <= 3'd0;
            res_data_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            alu_op_q   <= alu_op_d;
            alu_r2_q   <= alu_r2_d;
            alu_r3_q   <= alu_r3_d;
            rd_q       <= rd_d;
            res_rd_q   <= res_rd_d;
            res_data_q <= res_data_d;
        end
    end

    // Entry 0 is never written, so it keeps its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else if (rf_we) begin
            rf_q[res_rd_q] <= res_data_q;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.res_valid = (state_q == StWb);
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_r2    = alu_r2_q;
    assign bus.alu_r3    = alu_r3_q;
    assign bus.res_rd    = res_rd_q;
    assign bus.res_data  = res_data_q;
    assign dbg_data      = rf_q[dbg_addr];
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: ALU stub, register-file model and writeback scoreboard.
module tb_alu_issue_ctrl;
    typedef struct packed {
        logic [2:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    int          total = 0;
    int          bad   = 0;
    exp_t        q[$];
    logic [31:0] rf_m [8];
    logic [31:0] exp_r2, exp_r3;
    logic        prev_valid = 1'b0;
    int          w;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] stub(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a | b;
            3'd3:    return a & b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return a << 1;
            default: return 32'd0;
        endcase
    endfunction

    always_comb bus.alu_r1 = stub(bus.alu_op, bus.alu_r2, bus.alu_r3);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_dbg(input logic [2:0] addr, input logic [31:0] exp);
        dbg_addr = addr;
        #1;
        chk($sformatf("dbg_data[%0d]", addr), dbg_data, exp);
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge
    // with in_valid still asserted.
    task automatic send(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs2,
                        input logic [2:0] rs3, input logic [31:0] imm, output int waits);
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rd    = rd;
        bus.in_rs2   = rs2;
        bus.in_rs3   = rs3;
        bus.in_imm   = imm;
        waits        = 0;
        while (!bus.in_ready && waits < 8) begin
            @(negedge clk);
            waits++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $error("FAIL accept_timeout observed=in_ready low expected=accept within 8 cycles");
            bus.in_valid = 1'b0;
            return;
        end
        exp_r2 = rf_m[rs2];
        exp_r3 = rf_m[rs3];
        e.rd   = rd;
        e.data = (op == 3'b111) ? imm : stub(op, exp_r2, exp_r3);
        q.push_back(e);
        if (rd != 3'd0) rf_m[rd] = e.data;
        @(negedge clk);
        chk("res_valid_after_accept", {31'd0, bus.res_valid}, {31'd0, op == 3'b111});
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        q.delete();
        for (int i = 0; i < 8; i++) rf_m[i] = 32'd0;
    endtask

    task automatic chk_reset_state();
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("rst_alu_op", {29'd0, bus.alu_op}, 32'd0);
        chk("rst_alu_r2", bus.alu_r2, 32'd0);
        chk("rst_alu_r3", bus.alu_r3, 32'd0);
        chk("rst_res_rd", {29'd0, bus.res_rd}, 32'd0);
        chk("rst_res_data", bus.res_data, 32'd0);
        for (int i = 0; i < 8; i++) chk_dbg(3'(i), 32'd0);
    endtask

    // Writeback scoreboard and pulse-spacing check.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.res_valid) begin
                chk("res_valid_gap", {31'd0, prev_valid}, 32'd0);
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL unexpected_res_valid observed rd=%0d data=%h expected=none",
                           bus.res_rd, bus.res_data);
                end else begin
                    e = q.pop_front();
                    chk("res_rd", {29'd0, bus.res_rd}, {29'd0, e.rd});
                    chk("res_data", bus.res_data, e.data);
                end
            end
            prev_valid = bus.res_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        bus.in_op  = 3'd0;
        bus.in_rd  = 3'd0;
        bus.in_rs2 = 3'd0;
        bus.in_rs3 = 3'd0;
        bus.in_imm = 32'd0;
        dbg_addr   = 3'd0;
        do_reset();
        repeat (2) @(negedge clk);
        chk_reset_state();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while an ALU op sits in EXEC drops it without a writeback.
        send(3'b010, 3'd3, 3'd1, 3'd2, 32'd0, w);
        chk("exec_alu_op_pre_reset", {29'd0, bus.alu_op}, 32'd2);
        do_reset();
        #1;
        chk_reset_state();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("no_res_after_reset", {31'd0, bus.res_valid}, 32'd0);
        end

        // Two LOADIs with in_valid held high: accepts two cycles apart.
        send(3'b111, 3'd1, 3'd0, 3'd0, 32'h0000FFFF, w);
        chk("loadi_wb_in_ready", {31'd0, bus.in_ready}, 32'd0);
        send(3'b111, 3'd2, 3'd0, 3'd0, 32'hFFFF0000, w);
        chk("loadi_spacing", w, 32'd1);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk_dbg(3'd1, 32'h0000FFFF);
        chk_dbg(3'd2, 32'hFFFF0000);
        @(negedge clk);

        // OR through the ALU stub.
        send(3'b010, 3'd3, 3'd1, 3'd2, 32'd0, w);
        bus.in_valid = 1'b0;
        chk("exec_alu_op", {29'd0, bus.alu_op}, 32'd2);
        chk("exec_alu_r2", bus.alu_r2, 32'h0000FFFF);
        chk("exec_alu_r3", bus.alu_r3, 32'hFFFF0000);
        @(negedge clk);
        chk("wb_res_valid", {31'd0, bus.res_valid}, 32'd1);
        chk("wb_res_data", bus.res_data, 32'hFFFFFFFF);
        @(negedge clk);
        chk_dbg(3'd3, 32'hFFFFFFFF);
        @(negedge clk);

        // r0 is reported on writeback but never stored.
        send(3'b111, 3'd0, 3'd0, 3'd0, 32'h12345678, w);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk_dbg(3'd0, 32'd0);
        @(negedge clk);
        send(3'b100, 3'd6, 3'd0, 3'd1, 32'd0, w);
        bus.in_valid = 1'b0;
        chk("r0_alu_r2", bus.alu_r2, 32'd0);
        repeat (2) @(negedge clk);

        // Dependent op right after a LOADI sees the written value.
        send(3'b111, 3'd4, 3'd0, 3'd0, 32'hFF00FF00, w);
        send(3'b101, 3'd5, 3'd4, 3'd4, 32'd0, w);
        bus.in_valid = 1'b0;
        chk("dep_spacing", w, 32'd1);
        chk("dep_alu_r2", bus.alu_r2, 32'hFF00FF00);
        chk("dep_alu_r3", bus.alu_r3, 32'hFF00FF00);
        repeat (2) @(negedge clk);
        chk_dbg(3'd5, 32'h00FF00FF);
        @(negedge clk);

        // Back-to-back ALU ops: three-cycle throughput.
        send(3'b001, 3'd6, 3'd2, 3'd1, 32'd0, w);
        send(3'b011, 3'd6, 3'd6, 3'd2, 32'd0, w);
        chk("alu_spacing", w, 32'd2);

        // in_valid during EXEC/WB only: nothing is accepted.
        send(3'b000, 3'd7, 3'd1, 3'd2, 32'd0, w);
        bus.in_op  = 3'b111;
        bus.in_rd  = 3'd1;
        bus.in_imm = 32'hDEADBEEF;
        @(negedge clk);
        bus.in_rd  = 3'd2;
        bus.in_imm = 32'h0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("busy_in_ready", {31'd0, bus.in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        chk_dbg(3'd1, 32'h0000FFFF);
        chk_dbg(3'd2, 32'hFFFF0000);
        chk_dbg(3'd7, 32'hFFFFFFFF);
        repeat (3) @(negedge clk);
        chk_dbg(3'd6, rf_m[6]);
        chk("queue_empty", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential issue/writeback controller that drives the combinational 32-bit `ALU` block (ports `alu_op`, `r2`, `r3` → `r1`). It accepts one instruction at a time over a valid/ready handshake and reads operands from an internal 8×32 register file. It presents the operands to the ALU for one full cycle, captures the result, and writes it back. It sits between the instruction source and the ALU and replaces hand-driven ALU stimulus in system-level use.

## Interface
Parameters: none (data width 32, 8 registers, 3-bit op are fixed).
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  instruction offered
- `in_ready`  out  1  controller can accept; high only in IDLE
- `in_op`  in  3  ALU op code 000–110; 111 = LOADI (no ALU use)
- `in_rd`  in  3  destination register
- `in_rs2`  in  3  source register driven to ALU `r2`
- `in_rs3`  in  3  source register driven to ALU `r3`
- `in_imm`  in  32  immediate for LOADI; ignored otherwise
- `alu_op`  out  3  to ALU `alu_op`, registered
- `alu_r2`  out  32  to ALU `r2`, registered
- `alu_r3`  out  32  to ALU `r3`, registered
- `alu_r1`  in  32  from ALU `r1` (combinational result)
- `res_valid`  out  1  one-cycle pulse, writeback in progress
- `res_rd`  out  3  destination of current writeback
- `res_data`  out  32  value being written back
- `dbg_addr`  in  3  register file debug read address
- `dbg_data`  out  32  combinational read of `dbg_addr`

## Operation
- Register file is 8×32. `r0` always reads 0, and writes to it are discarded. The `res_*` outputs still report the write.
- FSM states: IDLE, EXEC, WB.
- IDLE: `in_ready`=1. The instruction is accepted on a rising edge with `in_valid`=1.
  - Non-LOADI: latch `alu_op`←`in_op`, `alu_r2`←RF[`in_rs2`], `alu_r3`←RF[`in_rs3`], and `rd`. Go to EXEC.
  - LOADI: latch `res_data`←`in_imm`, `res_rd`←`in_rd`. Go to WB. The ALU ports are unchanged.
- EXEC: ALU ports are stable for the whole cycle. At the end-of-cycle edge, `res_data`←`alu_r1` and `res_rd`←`rd`. Go to WB.
- WB: `res_valid`=1. At the end-of-cycle edge, RF[`res_rd`]←`res_data` (unless `res_rd`=0). Go to IDLE.
- The `alu_*` outputs hold their last values outside EXEC until the next non-LOADI accept.
- `in_valid` while `in_ready`=0 is ignored; nothing is queued.
- Operands are read at accept. The previous writeback has always completed by the time IDLE is reached, so there are no hazards.
- Unused `in_op` values (none besides 111) are not filtered. Ops 000–110 all go through the ALU; unary ops simply ignore `alu_r3`.

## Timing
- Reset (async assert, sync-safe deassert):
  - State goes to IDLE.
  - `in_ready`=1.
  - `alu_op`=0, `alu_r2`=0, `alu_r3`=0.
  - `res_valid`=0, `res_rd`=0, `res_data`=0.
  - All RF entries are 0.
  - An in-flight instruction is dropped with no `res_valid` pulse.
- ALU op accepted at edge T:
  - ALU ports are valid from T to T+1.
  - `res_valid` is high from T+1 to T+2.
  - RF is updated at T+2.
  - Next accept is possible at T+3 (3-cycle throughput).
- LOADI accepted at edge T:
  - `res_valid` is high from T to T+1.
  - RF is updated at T+1.
  - Next accept is possible at T+2.
- `dbg_data` reflects an RF write starting in the cycle after the write edge.
- `res_valid` is never high on two consecutive cycles.

## Test plan
- Reset mid-EXEC: assert `rst_n`=0 one cycle after accepting op 010 → immediately all outputs are 0, `in_ready`=1, and `dbg_data`=0 for every `dbg_addr`. No `res_valid` follows.
- LOADI r1←0x0000FFFF, then LOADI r2←0xFFFF0000 with `in_valid` held high → accepts are 2 cycles apart, each followed by a 1-cycle `res_valid` with the matching `res_rd`/`res_data`. Afterwards `dbg_data`(1)=0x0000FFFF and `dbg_data`(2)=0xFFFF0000.
- Op 010, rd=3, rs2=1, rs3=2, with a bench ALU stub returning 0xFFFFFFFF:
  - Cycle after accept: `alu_op`=010, `alu_r2`=0x0000FFFF, `alu_r3`=0xFFFF0000.
  - Next cycle: `res_valid`=1, `res_data`=0xFFFFFFFF.
  - Then `dbg_data`(3)=0xFFFFFFFF.
- r0 rules:
  - LOADI r0←0x12345678 → `res_valid` with `res_data`=0x12345678, but `dbg_data`(0) stays 0.
  - Op 100 with rs2=0 → `alu_r2`=0.
- Dependent back-to-back ops: LOADI r4←0xFF00FF00, then op 101 rd=5 rs2=4 rs3=4, presented with continuous `in_valid` → the second accept waits until IDLE and drives `alu_r2`=`alu_r3`=0xFF00FF00.
- Handshake: pulse `in_valid` only during EXEC/WB cycles → no accept, no `res_valid`, and RF is unchanged.
